reg_cir_seq: RTL
================

Name: reg_cir_seq

Overview:
- Command sequencer directly upstream of the 15-bit circular shift register.
- Accepts a "load value, then rotate N places left or right" command and drives the register's D / shift_l / shift_r inputs cycle by cycle.
- The register has no hold mode: both shift controls low, or both high, reloads D. This block therefore keeps a shadow copy of the register contents and re-presents it on D whenever idle, so the register's value persists.
- The shadow copy is also exported as the expected register value.

Parameters:
- W, 15, data width; must match the downstream register.
- CW, 4, width of the rotate-amount field; 2**CW >= W.

Ports:
- clk  input  1  clock; same clock as the downstream register.
- rst  input  1  synchronous, active-high reset. Asserted in the same cycles as the register's reset, so both clear to 0 together.
- start  input  1  command strobe; sampled only in IDLE.
- data_in  input  W  value to load into the register.
- dir  input  1  rotate direction: 0 = right, 1 = left.
- amount  input  CW  number of single-place rotations.
- D  output  W  register data input.
- shift_l  output  1  register rotate-left control.
- shift_r  output  1  register rotate-right control.
- busy  output  1  high when state != IDLE.
- done  output  1  one-cycle completion pulse.
- shadow  output  W  mirror of the register contents.

Behaviour:
- Reset: state=IDLE, shadow=0, cnt=0, D=0, shift_l=0, shift_r=0, busy=0, done=0. Reset mid-command aborts it immediately; no done pulse is issued.
- Control outputs are registered, so the register samples them on the following edge.
- The block never drives shift_l=shift_r=1.
- States:
  - IDLE: D=shadow, shift_l=shift_r=0, so the register reloads its own value. On start=1: capture data_in, dir and amt_eff into internal registers, go to LOAD.
  - amt_eff = amount if amount < W, else amount - W. With CW=4 this means amount 15 is treated as 0.
  - LOAD (1 cycle): D=captured data, shift_l=shift_r=0; shadow <= captured data. If amt_eff=0, go to DONE; else cnt <= amt_eff, go to SHIFT.
  - SHIFT: shift_l=dir and shift_r=~dir; D=shadow (ignored by the register).
  - Each SHIFT cycle, shadow rotates in the commanded direction: left = {shadow[W-2:0], shadow[W-1]}, right = {shadow[0], shadow[W-1:1]}. cnt decrements; when cnt reaches 1 in this cycle, go to DONE.
  - DONE (1 cycle): done=1, D=shadow, shift_l=shift_r=0. Go to IDLE.
- Timing: with start sampled at edge 0, LOAD occupies cycle 1, SHIFT occupies cycles 2..1+n, and done is high in cycle 2+n (n = amt_eff). Total command length = n+2 cycles after start.
- start while busy, including during the DONE cycle, is ignored and not queued. data_in, dir and amount only matter in the start cycle.
- Rotate wrap: n rotations left equals W-n rotations right. No shortest-path optimisation; exactly n steps are issued.
- Invariant: after every clock edge, shadow equals the downstream Q.

Test Plan:
- Reset, then idle 5 cycles -> D=0, shift_l=shift_r=0, shadow=0, busy=0, done=0 throughout.
- start, data_in=15'h0001, dir=1, amount=3 -> LOAD at cycle 1; shift_l=1 for cycles 2-4; done=1 at cycle 5; shadow=15'h0008 and register Q=15'h0008; both hold for 5 further idle cycles.
- start, data_in=15'h0001, dir=0, amount=1 -> shift_r=1 for one cycle; shadow=Q=15'h4000; done at cycle 3.
- start, data_in=15'h4000, dir=1, amount=14 -> 14 shift_l cycles; shadow=Q=15'h2000; done at cycle 16.
- amount=15 and amount=0, data_in=15'h1234 -> no shift cycles; done at cycle 2; shadow=Q=15'h1234. A second start at cycle 1 (mid-command) is ignored.
- start, data_in=15'h7FFF, dir=1, amount=5; assert rst at cycle 3 -> next cycle state=IDLE, shadow=0, Q=0; no done pulse; controls low.

Source files
------------

// File: rtl/reg_cir_seq.sv
// Command sequencer for a W-bit circular shift register that has no hold mode.
// A "load, then rotate N places" command is turned into a cycle-by-cycle
// stream of D / shift_l / shift_r. A shadow copy of the register contents is
// kept and re-presented on D whenever no shift is in progress, so the
// downstream value persists. All control outputs are registered.
module reg_cir_seq #(
  parameter int W  = 15,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  data_in,
  input  logic          dir,
  input  logic [CW-1:0] amount,
  output logic [W-1:0]  D,
  output logic          shift_l,
  output logic          shift_r,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  shadow
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam logic [CW:0]   W_EXT   = (CW+1)'(W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_reg, state_next;
  logic [W-1:0]  shadow_reg, shadow_next;
  logic [W-1:0]  data_reg, data_next;
  logic          dir_reg, dir_next;
  logic [CW-1:0] amt_reg, amt_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] amt_eff;
  logic [W-1:0]  rot_l, rot_r;

  logic [W-1:0]  d_reg, d_next;
  logic          shl_reg, shl_next;
  logic          shr_reg, shr_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  // Fold amounts >= W back into range; a full turn is a no-op.
  always_comb begin
    if ({1'b0, amount} < W_EXT) amt_eff = amount;
    else                        amt_eff = amount - W_EXT[CW-1:0];
  end

  // Single-place rotations of the shadow copy, matching the register's wiring.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_rot
      assign rot_l[gi] = shadow_reg[(gi + W - 1) % W];
      assign rot_r[gi] = shadow_reg[(gi + 1) % W];
    end
  endgenerate

  // Next-state logic: command capture, load, step counting, shadow tracking.
  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    data_next   = data_reg;
    dir_next    = dir_reg;
    amt_next    = amt_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          data_next  = data_in;
          dir_next   = dir;
          amt_next   = amt_eff;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        shadow_next = data_reg;
        if (amt_reg == '0) begin
          state_next = S_DONE;
        end else begin
          cnt_next   = amt_reg;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shadow_next = dir_reg ? rot_l : rot_r;
        cnt_next    = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs can be registered and
  // line up with the state they describe; only SHIFT ever raises a shift line.
  always_comb begin
    d_next    = (state_next == S_LOAD) ? data_next : shadow_next;
    shl_next  = (state_next == S_SHIFT) &&  dir_next;
    shr_next  = (state_next == S_SHIFT) && !dir_next;
    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_DONE);
  end

  // State, shadow, command and output registers; reset aborts any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      shadow_reg <= '0;
      data_reg   <= '0;
      dir_reg    <= 1'b0;
      amt_reg    <= '0;
      cnt_reg    <= '0;
      d_reg      <= '0;
      shl_reg    <= 1'b0;
      shr_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      data_reg   <= data_next;
      dir_reg    <= dir_next;
      amt_reg    <= amt_next;
      cnt_reg    <= cnt_next;
      d_reg      <= d_next;
      shl_reg    <= shl_next;
      shr_reg    <= shr_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign D       = d_reg;
  assign shift_l = shl_reg;
  assign shift_r = shr_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign shadow  = shadow_reg;

endmodule
